oam_dma: RTL

Sprite DMA engine for the 2A03, placed between `cpu_2a03` and the system bus. In pass-through it forwards CPU bus cycles unchanged. A CPU write to $4014 freezes the CPU through a clock-enable stall, then the engine copies page $NN00–$NNFF to PPU OAMDATA ($2004) as 256 read/write pairs. Afterwards it hands the bus back.

---
 rtl/oam_dma_if.sv | 22 ++
 rtl/oam_dma.sv | 93 +++++++++
 2 files changed

// File: rtl/oam_dma_if.sv
// Bus bundle between cpu_2a03, the sprite DMA engine and the system bus.
// The master side is the CPU/system environment; the slave side is the engine.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data_out;
    logic        cpu_rw;
    logic [7:0]  bus_data_in;
    logic [15:0] bus_addr;
    logic [7:0]  bus_data_out;
    logic        bus_rw;
    logic        cpu_stall;

    modport master (
        output cpu_addr, cpu_data_out, cpu_rw, bus_data_in,
        input  bus_addr, bus_data_out, bus_rw, cpu_stall
    );

    modport slave (
        input  cpu_addr, cpu_data_out, cpu_rw, bus_data_in,
        output bus_addr, bus_data_out, bus_rw, cpu_stall
    );
endinterface

// File: rtl/oam_dma.sv
// 2A03 sprite DMA: passes CPU cycles through, and on a write to the trigger
// address stalls the CPU and copies one 256-byte page to the OAM data port.
module oam_dma #(
    parameter logic [15:0] DMA_TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR    = 16'h2004
) (
    input  logic        clock,
    input  logic        reset,
    oam_dma_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  latch_q, latch_d;

    always_comb begin
        state_d          = state_q;
        phase_d          = ~phase_q;
        page_d           = page_q;
        idx_d            = idx_q;
        latch_d          = latch_q;
        bus.bus_addr     = bus.cpu_addr;
        bus.bus_rw       = bus.cpu_rw;
        bus.bus_data_out = bus.cpu_data_out;
        bus.cpu_stall    = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // The trigger write itself is still forwarded to the bus.
                if (!bus.cpu_rw && bus.cpu_addr == DMA_TRIGGER_ADDR) begin
                    page_d  = bus.cpu_data_out;
                    idx_d   = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                bus.bus_rw       = 1'b1;
                bus.bus_data_out = '0;
                // Land every READ on a phase-0 cycle.
                state_d          = phase_q ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
                bus.bus_rw       = 1'b1;
                bus.bus_data_out = '0;
                state_d          = S_READ;
            end
            S_READ: begin
                bus.bus_addr     = {page_q, idx_q};
                bus.bus_rw       = 1'b1;
                bus.bus_data_out = '0;
                latch_d          = bus.bus_data_in;
                state_d          = S_WRITE;
            end
            S_WRITE: begin
                bus.bus_addr     = OAM_DATA_ADDR;
                bus.bus_rw       = 1'b0;
                bus.bus_data_out = latch_q;
                if (idx_q == 8'hFF) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            page_q  <= '0;
            idx_q   <= '0;
            latch_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            latch_q <= latch_d;
        end
    end
endmodule
